mul_res_acc: RTL and testbench

MUL_RES_ACC -- requirements
Module: mul_res_acc

---
 rtl/mul_res_acc.sv | 171 +++++++++++++++++
 tb/tb_mul_res_acc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_res_acc.sv
// mul_res_acc: sums ACC_CNT signed Booth products, hands the total off via valid/ready.
// Define MUL_RES_ACC_SAT_EN to clamp the sum on overflow instead of wrapping.
module mul_res_acc #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int ACC_CNT    = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_end,
    input  logic [2*DATA_WIDTH-1:0]          i_res,
    input  logic                             i_cry,
    input  logic                             i_clr,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [ACC_WIDTH-1:0]             o_acc,
    output logic [$clog2(ACC_CNT+1)-1:0]     o_cnt,
    output logic                             o_ovf,
    output logic                             o_drop
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(ACC_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(ACC_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic                 r_end_q;
    logic [PW-1:0]        r_prod_q, r_prod_d;
    logic                 r_cry_q, r_cry_d;
    logic                 r_pend_vld_q, r_pend_vld_d;
    logic [PW-1:0]        r_pend_q, r_pend_d;
    logic                 r_pend_cry_q, r_pend_cry_d;
    logic [ACC_WIDTH-1:0] r_acc_q, r_acc_d;
    logic [CW-1:0]        r_cnt_q, r_cnt_d;
    logic                 r_ovf_q, r_ovf_d;
    logic                 r_drop_q, r_drop_d;

    logic                 ev;
    logic                 park;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] acc_new;
    logic                 add_ovf;
    logic [CW-1:0]        cnt_inc;

    assign ev       = i_end & ~r_end_q;
    assign prod_ext = ACC_WIDTH'($signed(r_prod_q));
    assign sum      = r_acc_q + prod_ext;
    assign cnt_inc  = r_cnt_q + CW'(1);
    assign add_ovf  = (r_acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
                    && (sum[ACC_WIDTH-1] != r_acc_q[ACC_WIDTH-1]);

`ifdef MUL_RES_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Overflow direction follows the sign both operands shared.
    assign acc_new = add_ovf
                   ? (r_acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX)
                   : sum;
`else
    assign acc_new = sum;
`endif

    always_comb begin
        state_d      = state_q;
        r_prod_d     = r_prod_q;
        r_cry_d      = r_cry_q;
        r_pend_vld_d = r_pend_vld_q;
        r_pend_d     = r_pend_q;
        r_pend_cry_d = r_pend_cry_q;
        r_acc_d      = r_acc_q;
        r_cnt_d      = r_cnt_q;
        r_ovf_d      = r_ovf_q;
        r_drop_d     = r_drop_q;
        park         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (r_pend_vld_q) begin
                    r_prod_d     = r_pend_q;
                    r_cry_d      = r_pend_cry_q;
                    r_pend_vld_d = 1'b0;
                    park         = ev;
                    state_d      = S_ACC;
                end else if (ev) begin
                    r_prod_d = i_res;
                    r_cry_d  = i_cry;
                    state_d  = S_ACC;
                end
            end
            S_ACC: begin
                r_acc_d = acc_new;
                r_cnt_d = cnt_inc;
                r_ovf_d = r_ovf_q | r_cry_q | add_ovf;
                park    = ev;
                state_d = (cnt_inc == CNT_MAX) ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                park = ev;
                if (i_ready) begin
                    r_acc_d = '0;
                    r_cnt_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An IDLE reload vacates the slot this same cycle.
        if (park) begin
            if (!r_pend_vld_q || state_q == S_IDLE) begin
                r_pend_vld_d = 1'b1;
                r_pend_d     = i_res;
                r_pend_cry_d = i_cry;
            end else begin
                r_drop_d = 1'b1;
            end
        end

        if (i_clr) begin
            state_d      = S_IDLE;
            r_pend_vld_d = 1'b0;
            r_acc_d      = '0;
            r_cnt_d      = '0;
            r_ovf_d      = 1'b0;
            r_drop_d     = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            r_end_q      <= 1'b0;
            r_prod_q     <= '0;
            r_cry_q      <= 1'b0;
            r_pend_vld_q <= 1'b0;
            r_pend_q     <= '0;
            r_pend_cry_q <= 1'b0;
            r_acc_q      <= '0;
            r_cnt_q      <= '0;
            r_ovf_q      <= 1'b0;
            r_drop_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_end_q      <= i_end;
            r_prod_q     <= r_prod_d;
            r_cry_q      <= r_cry_d;
            r_pend_vld_q <= r_pend_vld_d;
            r_pend_q     <= r_pend_d;
            r_pend_cry_q <= r_pend_cry_d;
            r_acc_q      <= r_acc_d;
            r_cnt_q      <= r_cnt_d;
            r_ovf_q      <= r_ovf_d;
            r_drop_q     <= r_drop_d;
        end
    end

    assign o_valid = (state_q == S_OUT);
    assign o_acc   = r_acc_q;
    assign o_cnt   = r_cnt_q;
    assign o_ovf   = r_ovf_q;
    assign o_drop  = r_drop_q;

endmodule

// File: tb/tb_mul_res_acc.sv
// Scoreboard bench for mul_res_acc: 16-bit and 8-bit accumulator instances
// share one stimulus stream; an integer model predicts every handed-off total.
module tb_mul_res_acc;
    localparam int CNT = 4;
    localparam int CW  = $clog2(CNT + 1);

    logic          clk = 1'b0;
    logic          rst, iend, icry, iclr, irdy;
    logic [7:0]    ires;
    logic          v0, v1, ov0, ov1, dr0, dr1;
    logic [15:0]   a0;
    logic [7:0]    a1;
    logic [CW-1:0] c0, c1;

    always #5 clk = ~clk;

    mul_res_acc #(.DATA_WIDTH(4), .ACC_WIDTH(16), .ACC_CNT(CNT)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_end(iend), .i_res(ires), .i_cry(icry),
        .i_clr(iclr), .o_valid(v0), .i_ready(irdy), .o_acc(a0), .o_cnt(c0),
        .o_ovf(ov0), .o_drop(dr0));

    mul_res_acc #(.DATA_WIDTH(4), .ACC_WIDTH(8), .ACC_CNT(CNT)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_end(iend), .i_res(ires), .i_cry(icry),
        .i_clr(iclr), .o_valid(v1), .i_ready(irdy), .o_acc(a1), .o_cnt(c1),
        .o_ovf(ov1), .o_drop(dr1));

    typedef struct {
        int acc;
        int cnt;
        bit ovf;
        bit drop;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int n_chk = 0;
    int n_fail = 0;
    int n_hs = 0;

    int W[2] = '{16, 8};
    int macc[2];
    int mcnt;
    bit movf[2];
    bit mdrop[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_clr();
        for (int i = 0; i < 2; i++) begin
            macc[i] = 0;
            movf[i] = 0;
            mdrop[i] = 0;
        end
        mcnt = 0;
    endtask

    task automatic model_add(input logic [7:0] p, input bit c);
        int sp;
        sp = $signed(p);
        for (int i = 0; i < 2; i++) begin
            int v, hi, lo;
            bit o;
            v  = macc[i] + sp;
            hi = (1 << (W[i] - 1)) - 1;
            lo = -(1 << (W[i] - 1));
            o  = (v > hi) || (v < lo);
            if (o) begin
`ifdef MUL_RES_ACC_SAT_EN
                v = (v > hi) ? hi : lo;
`else
                v = (v > hi) ? v - (1 << W[i]) : v + (1 << W[i]);
`endif
            end
            macc[i] = v;
            movf[i] = movf[i] | o | c;
        end
        mcnt++;
        if (mcnt == CNT) begin
            q0.push_back('{macc[0], mcnt, movf[0], mdrop[0]});
            q1.push_back('{macc[1], mcnt, movf[1], mdrop[1]});
            macc[0] = 0;
            macc[1] = 0;
            mcnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && irdy && (v0 || v1)) begin
            n_hs++;
            if (q0.size() == 0 || q1.size() == 0) begin
                chk("unexpected_result", 32'(q0.size() + q1.size()), 32'd2);
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("w16_valid", 32'(v0), 32'd1);
                chk("w16_acc", 32'(a0), e0.acc & 32'hFFFF);
                chk("w16_cnt", 32'(c0), 32'(e0.cnt));
                chk("w16_ovf", 32'(ov0), 32'(e0.ovf));
                chk("w16_drop", 32'(dr0), 32'(e0.drop));
                chk("w8_valid", 32'(v1), 32'd1);
                chk("w8_acc", 32'(a1), e1.acc & 32'hFF);
                chk("w8_cnt", 32'(c1), 32'(e1.cnt));
                chk("w8_ovf", 32'(ov1), 32'(e1.ovf));
                chk("w8_drop", 32'(dr1), 32'(e1.drop));
            end
        end
    end

    task automatic send(input logic [7:0] p, input bit c, input bit mdl);
        if (mdl) model_add(p, c);
        @(posedge clk);
        #1;
        iend = 1'b1;
        ires = p;
        icry = c;
        @(posedge clk);
        #1;
        iend = 1'b0;
        icry = 1'b0;
        repeat ($urandom_range(3, 5)) @(posedge clk);
    endtask

    task automatic clr();
        @(posedge clk);
        #1 iclr = 1'b1;
        @(posedge clk);
        #1 iclr = 1'b0;
        model_clr();
    endtask

    task automatic release_wait();
        int s;
        s = n_hs;
        @(posedge clk);
        #1 irdy = 1'b1;
        for (int i = 0; i < 50 && n_hs == s; i++) @(posedge clk);
        chk("handshake_seen", 32'(n_hs != s), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iend = 1'b0; icry = 1'b0; iclr = 1'b0;
        irdy = 1'b1; ires = '0;
        model_clr();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_acc", 32'(a0), 32'd0);
        chk("rst_cnt", 32'(c0), 32'd0);
        chk("rst_ovf", 32'(ov0), 32'd0);
        chk("rst_drop", 32'(dr0), 32'd0);

        repeat (CNT) send(8'h2A, 1'b0, 1'b1);
        clr();

        send(8'h2A, 1'b0, 1'b1);
        send(8'hE2, 1'b0, 1'b1);
        send(8'h2A, 1'b0, 1'b1);
        send(8'hE2, 1'b0, 1'b1);
        clr();

        irdy = 1'b0;
        repeat (CNT) send(8'h40, 1'b0, 1'b1);
        @(negedge clk);
        chk("sat_w16_acc", 32'(a0), 32'h0100);
`ifdef MUL_RES_ACC_SAT_EN
        chk("sat_w8_acc", 32'(a1), 32'h7F);
`else
        chk("wrap_w8_acc", 32'(a1), 32'h00);
`endif
        chk("ovf_w8", 32'(ov1), 32'd1);
        release_wait();
        clr();

        irdy = 1'b0;
        repeat (CNT - 1) send(8'h2A, 1'b0, 1'b1);
        // The second parked event below is dropped before this result leaves.
        mdrop = '{1'b1, 1'b1};
        send(8'h2A, 1'b0, 1'b1);
        send(8'h2A, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_acc_hold", 32'(a0), 32'h00A8);
        chk("bp_valid_hold", 32'(v0), 32'd1);
        repeat (8) @(posedge clk);
        release_wait();
        model_add(8'h2A, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_after_cnt", 32'(c0), 32'd1);
        chk("bp_after_acc", 32'(a0), 32'h002A);
        chk("bp_after_drop", 32'(dr0), 32'd1);

        clr();
        send(8'hE2, 1'b0, 1'b1);
        send(8'hE2, 1'b0, 1'b1);
        clr();
        @(negedge clk);
        chk("clr_acc", 32'(a0), 32'd0);
        chk("clr_cnt", 32'(c0), 32'd0);
        repeat (CNT) send(8'hE2, 1'b0, 1'b1);

        clr();
        for (int g = 0; g < 12; g++) begin
            bit bp;
            bp = ($urandom_range(0, 1) == 1);
            for (int j = 0; j < CNT; j++) begin
                if (j == CNT - 1 && bp) irdy = 1'b0;
                send(8'($urandom_range(0, 255)),
                     ($urandom_range(0, 7) == 0), 1'b1);
            end
            if (bp) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                release_wait();
            end
        end

        irdy = 1'b0;
        repeat (CNT) send(8'h2A, 1'b0, 1'b1);
        @(negedge clk);
        chk("pre_rst_valid", 32'(v0), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        model_clr();
        @(negedge clk);
        chk("mid_rst_valid", 32'(v0), 32'd0);
        chk("mid_rst_acc", 32'(a0), 32'd0);
        chk("mid_rst_cnt", 32'(c0), 32'd0);
        chk("mid_rst_flags", 32'({ov0, dr0, ov1, dr1}), 32'd0);
        chk("mid_rst_w8_valid", 32'(v1), 32'd0);
        irdy = 1'b1;

        @(posedge clk);
        #1 rst = 1'b1;
        iend = 1'b1;
        ires = 8'h05;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("held_end_acc", 32'(a0), 32'h0005);
        chk("held_end_cnt", 32'(c0), 32'd1);
        iend = 1'b0;
        repeat (3) @(posedge clk);

        chk("q_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
